// File: rtl/seq_alu.sv
// Sequential Hack ALU with valid/ready handshakes and an optional shift-add multiplier.
// Define SEQ_ALU_MUL_EN to build the multiplier; without it every request runs as a Hack op.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic [WIDTH-1:0] x_pre, y_pre, hack_r, hack_res;
  logic             accept;

  // zero-then-negate preprocessing collapses to one XOR/AND per bit
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pre
    assign x_pre[gi] = nx ^ (x[gi] & ~zx);
    assign y_pre[gi] = ny ^ (y[gi] & ~zy);
  end

  assign hack_r   = f ? (x_pre + y_pre) : (x_pre & y_pre);
  assign hack_res = no ? ~hack_r : hack_r;

  assign in_ready  = !rst && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);
  assign out       = out_reg;
  assign zr        = (out_reg == '0);
  assign ng        = out_reg[WIDTH-1];

`ifdef SEQ_ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [WIDTH-1:0] acc_reg, acc_next, acc_sum;
  logic [CW-1:0]    cnt_reg, cnt_next;

  assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`else
  logic unused_mul;
  assign unused_mul = mul;
`endif

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
`ifdef SEQ_ALU_MUL_EN
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
          state_next = DONE;
          out_next   = hack_res;
`ifdef SEQ_ALU_MUL_EN
          if (mul) begin
            state_next  = BUSY;
            out_next    = out_reg;
            mcand_next  = x_pre;
            mplier_next = y_pre;
            acc_next    = '0;
            cnt_next    = '0;
          end
`endif
        end else if ((state_reg == DONE) && out_ready) begin
          state_next = IDLE;
        end
      end
      BUSY: begin
`ifdef SEQ_ALU_MUL_EN
        // one multiplier bit per cycle; the last step lands straight in out
        acc_next    = acc_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) begin
          state_next = DONE;
          out_next   = acc_sum;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      out_reg   <= '0;
`ifdef SEQ_ALU_MUL_EN
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
`endif
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
`ifdef SEQ_ALU_MUL_EN
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=16): directed vectors plus a queue-based
// reference model checked every cycle. Follows SEQ_ALU_MUL_EN like the design.
module tb_seq_alu;

`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, zr, ng;
  logic [15:0] x, y, out;
  logic        zx, nx, zy, ny, f, no, mul;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int xfers = 0;

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;
  exp_t q[$];

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mul(mul),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .zr(zr), .ng(ng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // control vector packing: {zx, nx, zy, ny, f, no, mul}
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [6:0] c);
    logic [15:0] xp, yp, r;
    logic [31:0] p;
    xp = c[6] ? 16'h0000 : a;
    if (c[5]) xp = ~xp;
    yp = c[4] ? 16'h0000 : b;
    if (c[3]) yp = ~yp;
    if (MUL_EN && c[0]) begin
      p = xp * yp;
      return p[15:0];
    end
    r = c[2] ? 16'(xp + yp) : (xp & yp);
    return c[1] ? ~r : r;
  endfunction

  // reference model and per-cycle comparison
  always @(negedge clk) begin
    logic exp_rdy;
    cyc++;
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      q.delete();
    end else begin
      if (q.size() == 0) exp_rdy = 1'b1;
      else if (cyc >= q[0].due) exp_rdy = out_ready;
      else exp_rdy = 1'b0;
      chk("in_ready", in_ready, exp_rdy);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", out_valid, 0);
        end else begin
          chk("out", out, q[0].val);
          chk("zr", zr, q[0].val == 16'h0);
          chk("ng", ng, q[0].val[15]);
          chk("not_early", cyc >= q[0].due, 1);
          if (out_ready) begin
            xfers++;
            $display("xfer %0d: out=%h zr=%b ng=%b cycle=%0d", xfers, out, zr, ng, cyc);
            void'(q.pop_front());
          end
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        chk("late_valid", out_valid, 1);
      end
      if (in_valid && in_ready)
        q.push_back('{model(x, y, {zx, nx, zy, ny, f, no, mul}),
                      cyc + ((MUL_EN && mul) ? 17 : 1)});
    end
  end

  task automatic send(input logic [15:0] xa, input logic [15:0] ya, input logic [6:0] c);
    int n;
    @(posedge clk);
    #1;
    x = xa;
    y = ya;
    {zx, nx, zy, ny, f, no, mul} = c;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [15:0] vx[4]   = '{16'd10, 16'h00F0, 16'd7, 16'd9};
  logic [15:0] vy[4]   = '{16'd20, 16'h0FF0, 16'd0, 16'd9};
  logic [6:0]  vc[4]   = '{7'b0000100, 7'b0000000, 7'b0011010, 7'b0100110};
  logic [15:0] vexp[4] = '{16'h001E, 16'h00F0, 16'hFFF8, 16'h0000};

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; {zx, nx, zy, ny, f, no, mul} = '0;

    // model pins
    chk("pin_add", model(16'd5, 16'd3, 7'b0000100), 16'h0008);
    chk("pin_sub", model(16'd3, 16'd5, 7'b0100110), 16'hFFFE);
    chk("pin_mul", model(16'd300, 16'd300, 7'b0000101), MUL_EN ? 16'h5F90 : 16'h0258);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 16'h0000);
    chk("rst_zr", zr, 1);
    chk("rst_ng", ng, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);

    // 5 + 3
    send(16'd5, 16'd3, 7'b0000100);
    @(negedge clk);
    chk("add_valid", out_valid, 1);
    chk("add_out", out, 16'h0008);
    chk("add_zr", zr, 0);
    chk("add_ng", ng, 0);

    // x - y and constant zero
    send(16'd3, 16'd5, 7'b0100110);
    @(negedge clk);
    chk("sub_out", out, 16'hFFFE);
    chk("sub_ng", ng, 1);
    chk("sub_zr", zr, 0);
    send(16'd3, 16'd5, 7'b1010100);
    @(negedge clk);
    chk("zero_out", out, 16'h0000);
    chk("zero_zr", zr, 1);

    // multiply (or Hack x+y when built without the multiplier)
    send(16'd300, 16'd300, 7'b0000101);
    if (MUL_EN) begin
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        chk("mul_busy_in_ready", in_ready, 0);
        chk("mul_busy_valid", out_valid, 0);
      end
      @(negedge clk);
      chk("mul_valid", out_valid, 1);
      chk("mul_out", out, 16'h5F90);
    end else begin
      @(negedge clk);
      chk("nomul_valid", out_valid, 1);
      chk("nomul_out", out, 16'h0258);
    end

    // backpressure hold with changing inputs
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    send(16'd5, 16'd3, 7'b0000100);
    base = xfers;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      x = 16'($urandom);
      y = 16'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_out", out, 16'h0008);
      chk("hold_zr", zr, 0);
      chk("hold_ng", ng, 0);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", out_valid, 1);
    @(negedge clk);
    chk("after_release_valid", out_valid, 0);
    chk("single_xfer", xfers - base, 1);

    // reset in the middle of a multiply
    send(16'd300, 16'd300, 7'b0000101);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_out", out, 16'h0000);
    chk("midrst_zr", zr, 1);
    chk("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
    end

    // four back-to-back Hack ops
    @(posedge clk);
    #1;
    x = vx[0]; y = vy[0]; {zx, nx, zy, ny, f, no, mul} = vc[0]; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_ready0", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 3) begin
        x = vx[k+1]; y = vy[k+1]; {zx, nx, zy, ny, f, no, mul} = vc[k+1];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b_valid", out_valid, 1);
      chk("b2b_out", out, vexp[k]);
      if (k < 3) chk("b2b_ready", in_ready, 1);
    end

    repeat (5) @(posedge clk);
    chk("drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
